// File: rtl/io_timer.sv
// Memory-mapped programmable down-counter timer on the non-cacheable IO bus.
// A prescaler divides the clock into ticks; each tick decrements COUNT, expiry sets PENDING.
module io_timer #(
    parameter logic [31:0] BASE_ADDRESS   = 32'hffff_0200,
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_write_en,
    input  logic        io_read_en,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_read_hit,
    output logic        interrupt_req
);

    localparam logic [2:0] OffCtrl     = 3'd0;
    localparam logic [2:0] OffReload   = 3'd1;
    localparam logic [2:0] OffCount    = 3'd2;
    localparam logic [2:0] OffStatus   = 3'd3;
    localparam logic [2:0] OffPrescale = 3'd4;

    // Address decode
    logic       block_hit;
    logic [2:0] offset;
    logic       wr_ctrl;
    logic       wr_reload;
    logic       wr_count;
    logic       wr_status;
    logic       wr_prescale;

    assign block_hit   = (io_address[31:5] == BASE_ADDRESS[31:5]);
    assign offset      = io_address[4:2];
    assign wr_ctrl     = io_write_en && block_hit && (offset == OffCtrl);
    assign wr_reload   = io_write_en && block_hit && (offset == OffReload);
    assign wr_count    = io_write_en && block_hit && (offset == OffCount);
    assign wr_status   = io_write_en && block_hit && (offset == OffStatus);
    assign wr_prescale = io_write_en && block_hit && (offset == OffPrescale);

    logic unused_bits;
    assign unused_bits = ^{io_address[1:0], io_write_data};

    // Architectural state
    logic                      en_q, en_d;
    logic                      auto_q, auto_d;
    logic                      irq_en_q, irq_en_d;
    logic                      pending_q, pending_d;
    logic [COUNTER_WIDTH-1:0]  reload_q, reload_d;
    logic [COUNTER_WIDTH-1:0]  count_q, count_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      rhit_q, rhit_d;

    logic tick;
    logic expiry;

    assign tick   = en_q && (pcnt_q == prescale_q);
    assign expiry = tick && (count_q == '0);

    // Prescaler: free-running while enabled, cleared by any CTRL write so a
    // newly (re)started timer always begins a full prescale period.
    always_comb begin
        pcnt_d = pcnt_q;
        if (!en_q || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);
        end
        if (wr_ctrl) begin
            pcnt_d = '0;
        end
    end

    // Counter, control and status next-state; later assignments take priority.
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        pending_d  = pending_q;
        reload_d   = reload_q;
        count_d    = count_q;
        prescale_d = prescale_q;

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - COUNTER_WIDTH'(1);
            end else if (auto_q) begin
                count_d = reload_q;
            end
        end

        if (wr_status && io_write_data[0]) begin
            pending_d = 1'b0;
        end

        if (expiry) begin
            pending_d = 1'b1;
            if (!auto_q) begin
                en_d = 1'b0;
            end
        end

        if (wr_ctrl) begin
            en_d     = io_write_data[0];
            auto_d   = io_write_data[1];
            irq_en_d = io_write_data[2];
        end

        if (wr_reload) begin
            reload_d = io_write_data[COUNTER_WIDTH-1:0];
        end

        if (wr_count) begin
            count_d = io_write_data[COUNTER_WIDTH-1:0];
        end

        if (wr_prescale) begin
            prescale_d = io_write_data[PRESCALE_WIDTH-1:0];
        end
    end

    // Read path samples pre-write register values.
    logic [31:0] rd_value;

    always_comb begin
        rd_value = '0;
        case (offset)
            OffCtrl:     rd_value = {29'd0, irq_en_q, auto_q, en_q};
            OffReload:   rd_value = 32'(reload_q);
            OffCount:    rd_value = 32'(count_q);
            OffStatus:   rd_value = {31'd0, pending_q};
            OffPrescale: rd_value = 32'(prescale_q);
            default:     rd_value = '0;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        rhit_d  = rhit_q;
        if (io_read_en) begin
            rhit_d  = block_hit;
            rdata_d = block_hit ? rd_value : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            pending_q  <= 1'b0;
            reload_q   <= '0;
            count_q    <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            rdata_q    <= '0;
            rhit_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            pending_q  <= pending_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            rdata_q    <= rdata_d;
            rhit_q     <= rhit_d;
        end
    end

    assign io_read_data  = rdata_q;
    assign io_read_hit   = rhit_q;
    assign interrupt_req = pending_q & irq_en_q;

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: reads push expected responses into a scoreboard,
// a monitor pops and compares one cycle after each io_read_en.
module tb_io_timer;

    localparam logic [31:0] Base = 32'hffff_0200;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_write_en;
    logic        io_read_en;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_read_hit;
    logic        interrupt_req;

    io_timer dut (
        .clk          (clk),
        .reset        (reset),
        .io_write_en  (io_write_en),
        .io_read_en   (io_read_en),
        .io_address   (io_address),
        .io_write_data(io_write_data),
        .io_read_data (io_read_data),
        .io_read_hit  (io_read_hit),
        .interrupt_req(interrupt_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        hit;
        logic [31:0] data;
        bit          chk_irq;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic rd_seen  = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    always @(posedge clk) rd_seen <= io_read_en;

    // Monitor: response is valid the cycle after a read strobe.
    always @(negedge clk) begin
        if (rd_seen) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: read response with no expectation");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hit"}, {31'd0, io_read_hit}, {31'd0, e.hit});
                check({e.name, "_data"}, io_read_data, e.data);
                if (e.chk_irq) check({e.name, "_irq"}, {31'd0, interrupt_req}, {31'd0, e.irq});
            end
        end
    end

    task automatic access(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                          input bit re, input logic hit, input logic [31:0] exp,
                          input string name, input bit ci, input logic irq);
        exp_t e;
        io_address    = addr;
        io_write_en   = we;
        io_write_data = wdata;
        io_read_en    = re;
        if (re) begin
            e.name = name; e.hit = hit; e.data = exp; e.chk_irq = ci; e.irq = irq;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        io_write_en = 1'b0;
        io_read_en  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        access(Base + 32'(off), 1'b1, d, 1'b0, 1'b0, 32'd0, "", 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string name,
                      input bit ci = 1'b0, input logic irq = 1'b0);
        access(Base + 32'(off), 1'b0, 32'd0, 1'b1, 1'b1, exp, name, ci, irq);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; io_write_en = 1'b0; io_read_en = 1'b0;
        io_address = '0; io_write_data = '0;
        idle(3);
        reset = 1'b0;
        idle(1);

        // Reset state of every offset, then a miss
        for (int i = 0; i < 8; i++) begin
            logic [4:0] off;
            off = 5'(i * 4);
            rd(off, 32'd0, $sformatf("reset_off%0d", i * 4), 1'b1, 1'b0);
        end
        access(32'h0000_0100, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, "miss", 1'b0, 1'b0);

        // One-shot countdown, PRESCALE=0
        wr(5'h04, 32'd5);
        wr(5'h08, 32'd3);
        wr(5'h10, 32'd0);
        wr(5'h00, 32'h5);
        rd(5'h08, 32'd3, "os_c1");
        rd(5'h08, 32'd2, "os_c2");
        rd(5'h08, 32'd1, "os_c3");
        rd(5'h08, 32'd0, "os_c4", 1'b1, 1'b1);
        rd(5'h0c, 32'd1, "os_pend", 1'b1, 1'b1);
        rd(5'h00, 32'h4, "os_en_off");
        rd(5'h08, 32'd0, "os_cnt_hold");
        wr(5'h0c, 32'd1);
        rd(5'h0c, 32'd0, "os_w1c", 1'b1, 1'b0);

        // Auto-reload with PRESCALE=3: ticks every 4 cycles, expiry at 8, 20
        wr(5'h10, 32'd3);
        wr(5'h08, 32'd1);
        wr(5'h04, 32'd2);
        wr(5'h00, 32'h7);
        idle(7);
        rd(5'h08, 32'd0, "ar_c8");
        rd(5'h0c, 32'd1, "ar_pend", 1'b1, 1'b1);
        rd(5'h08, 32'd2, "ar_reload");
        wr(5'h0c, 32'd1);
        rd(5'h0c, 32'd0, "ar_clr", 1'b1, 1'b0);
        idle(7);
        wr(5'h0c, 32'd1);                 // W1C in the expiry cycle
        rd(5'h0c, 32'd1, "w1c_vs_set", 1'b1, 1'b1);
        rd(5'h08, 32'd2, "ar_reload2");
        idle(1);
        wr(5'h08, 32'd10);                // COUNT write in a tick cycle
        rd(5'h08, 32'd10, "cnt_wr_wins");
        wr(5'h00, 32'h0);
        wr(5'h0c, 32'd1);

        // Simultaneous read/write, reserved space, ignored bits
        wr(5'h04, 32'd7);
        access(Base + 32'h4, 1'b1, 32'd9, 1'b1, 1'b1, 32'd7, "rw_old", 1'b0, 1'b0);
        rd(5'h04, 32'd9, "rw_new");
        access(Base + 32'h7, 1'b0, 32'd0, 1'b1, 1'b1, 32'd9, "unaligned", 1'b0, 1'b0);
        wr(5'h18, 32'hdead_beef);
        rd(5'h18, 32'd0, "reserved");
        wr(5'h00, 32'hffff_fff0);
        rd(5'h00, 32'd0, "ctrl_upper");

        // Reset mid-count
        wr(5'h10, 32'd2);
        wr(5'h08, 32'd100);
        wr(5'h00, 32'h5);
        rd(5'h08, 32'd100, "pre_reset");
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        rd(5'h00, 32'd0, "rst_ctrl", 1'b1, 1'b0);
        rd(5'h08, 32'd0, "rst_count");
        rd(5'h04, 32'd0, "rst_reload");
        rd(5'h10, 32'd0, "rst_prescale");
        idle(5);
        rd(5'h08, 32'd0, "rst_no_tick");
        rd(5'h0c, 32'd0, "rst_status", 1'b1, 1'b0);

        idle(3);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
